regwrite_scoreboard: RTL
========================

Name: regwrite_scoreboard

Overview:
- Write-side companion to the decode-stage register-read decoding: decodes which register, if any, each issuing instruction writes.
- Tracks in-flight writes per register and stalls decode while a source register the instruction reads still has a write pending.
- Sits between ID and the writeback stage. The writeback stage reports completed register writes back into the block.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; maximum in-flight writes to one register = 2^CNT_W - 1.
- NREG, 32, number of architectural registers; register 0 is hardwired and never tracked.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  instruction present in ID
- id_op  input  6  opcode
- id_funct  input  6  R-type function field
- id_rs  input  5  rs field
- id_rt  input  5  rt field
- id_rd  input  5  rd field
- id_read_rs  input  1  instruction reads rs (from read decoding)
- id_read_rt  input  1  instruction reads rt (from read decoding)
- wb_valid  input  1  writeback retires a register write this cycle
- wb_reg  input  5  register written by that writeback
- stall  output  1  hold ID; instruction not issued this cycle
- wr_en  output  1  decoded: instruction writes a register (combinational)
- wr_dst  output  5  decoded destination register (combinational)
- pending_mask  output  32  bit i = counter i nonzero (registered view)
- wb_underflow  output  1  sticky error flag: writeback arrived for a register with count 0

Behaviour:
- Write decode (combinational):
  - op 000000 with funct ADD/ADDU/SUB/AND/OR/NOR/SLT/SLTU/SLL/SRL/SRA -> wr_dst = rd. JR and unknown funct -> no write.
  - ADDI 001000, ADDIU 001001, SLTI 001010, ANDI 001100, ORI 001101, LW 100011 -> wr_dst = rt.
  - JAL 000011 -> wr_dst = 31.
  - COP0 010000 with rs = 00000 (MFC0) -> wr_dst = rt.
  - SW, BEQ, BNE, J and all others -> wr_en = 0.
  - wr_en is forced to 0 when the decoded wr_dst = 0. wr_dst = 0 whenever wr_en = 0.
- Hazard:
  - wb_hit(r) = wb_valid && wb_reg == r && r != 0.
  - eff(r) = cnt[r] - (wb_hit(r) && cnt[r] != 0). Writeback-this-cycle bypass: the register file is write-first.
  - stall = id_valid && ((id_read_rs && eff(rs) != 0) || (id_read_rt && eff(rt) != 0) || (wr_en && cnt[wr_dst] == max && !wb_hit(wr_dst))).
  - Register 0 never stalls.
- Issue: issue = id_valid && !stall. On issue with wr_en, cnt[wr_dst] increments at the clock edge.
- Retire: on wb_hit(r) with cnt[r] != 0, cnt[r] decrements.
- Same cycle, same register, issue and retire: count unchanged.
- Same cycle, different registers, issue and retire: both counters update.
- wb_hit on a register with count 0: counter stays 0 and wb_underflow sets. It clears only on reset.
- Counters never wrap. Saturation is prevented by the full-stall term.
- Latency:
  - A write becomes visible to the hazard check the cycle after issue.
  - A retire clears the hazard in the same cycle as wb_valid (bypass).
- Reset (async, rst_n low): all counters 0, pending_mask 0, wb_underflow 0.
  - stall follows its combinational inputs.
  - Reset asserted mid-operation drops all pending state immediately.
  - Deassertion is synchronised externally.
- pending_mask[0] is always 0.

Test Plan:
- Reset: hold rst_n = 0, apply wb_valid = 1, wb_reg = 5 -> pending_mask = 0, wb_underflow = 0. Release; next cycle state unchanged except wb_underflow = 1 if wb_valid is still driven.
- RAW stall:
  - Issue ADDI rt = 8 -> cnt[8] = 1, pending_mask[8] = 1.
  - Next cycle, ADD rs = 8, id_read_rs = 1 -> stall = 1.
  - When wb_valid = 1, wb_reg = 8 -> stall = 0 that same cycle and the ADD issues.
- Decode table:
  - SW -> wr_en = 0.
  - JAL -> wr_dst = 31.
  - JR -> wr_en = 0.
  - MFC0 rt = 12 -> wr_dst = 12.
  - ADD rd = 0 -> wr_en = 0 and no counter change.
  - LW rt = 9 -> wr_dst = 9.
- Saturation: issue 3 writes to reg 4 without retire -> cnt = 3. A fourth writer stalls. Retiring the same cycle allows issue and cnt stays 3.
- Simultaneous: issue write to reg 7 while wb retires reg 7 at cnt 1 -> cnt[7] = 1. Issue reg 7 while retiring reg 3 -> cnt[7] +1, cnt[3] -1.
- Underflow: wb_valid with wb_reg = 20 at count 0 -> wb_underflow = 1 and stays set. Register 0 writeback -> no flag.

Source files
------------

// File: rtl/regwrite_scoreboard.sv
// regwrite_scoreboard
// Write-side register scoreboard sitting between ID and writeback.
// Decodes the destination register of the instruction in ID, keeps a
// saturating-free count of in-flight writes per architectural register and
// stalls ID while a source register still has a write outstanding (or the
// destination counter is full). Writeback retires writes, with a same-cycle
// bypass so a retiring register no longer blocks the reader.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_valid              instruction present in ID
//   id_op, id_funct       opcode / R-type function field
//   id_rs, id_rt, id_rd   register fields
//   id_read_rs/rt         instruction reads rs / rt
//   wb_valid, wb_reg      writeback retires a write to wb_reg this cycle
//   stall                 hold ID; instruction not issued this cycle
//   wr_en, wr_dst         decoded destination (combinational)
//   pending_mask          bit i set while register i has writes in flight
//   wb_underflow          sticky: writeback seen for a register with count 0
module regwrite_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [5:0]      id_op,
    input  logic [5:0]      id_funct,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic [4:0]      id_rd,
    input  logic            id_read_rs,
    input  logic            id_read_rt,
    input  logic            wb_valid,
    input  logic [4:0]      wb_reg,
    output logic            stall,
    output logic            wr_en,
    output logic [4:0]      wr_dst,
    output logic [NREG-1:0] pending_mask,
    output logic            wb_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg  [NREG];
    logic [CNT_W-1:0] cnt_next [NREG];
    logic             wb_underflow_reg;
    logic             underflow_hit;
    logic             dec_en;
    logic [4:0]       dec_dst;
    logic             issue;

    // ---------------- write decode ----------------
    always_comb begin
        dec_en  = 1'b0;
        dec_dst = 5'd0;
        case (id_op)
            6'b000000: begin
                case (id_funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100101,
                    6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                    6'b000011: begin
                        dec_en  = 1'b1;
                        dec_dst = id_rd;
                    end
                    default: ;  // JR and unknown functs write nothing
                endcase
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
            6'b100011: begin
                dec_en  = 1'b1;
                dec_dst = id_rt;
            end
            6'b000011: begin
                dec_en  = 1'b1;
                dec_dst = 5'd31;
            end
            6'b010000: begin
                // only MFC0 (rs = 0) moves into the GPR file
                if (id_rs == 5'd0) begin
                    dec_en  = 1'b1;
                    dec_dst = id_rt;
                end
            end
            default: ;
        endcase
    end

    // r0 is hardwired, so a write to it is not a write at all
    assign wr_en  = dec_en && (dec_dst != 5'd0);
    assign wr_dst = wr_en ? dec_dst : 5'd0;

    // ---------------- hazard detection ----------------
    logic             rs_hit, rt_hit, dst_hit;
    logic [CNT_W-1:0] rs_eff, rt_eff;
    logic             dst_full;

    always_comb begin
        rs_hit  = wb_valid && (wb_reg == id_rs) && (id_rs != 5'd0);
        rt_hit  = wb_valid && (wb_reg == id_rt) && (id_rt != 5'd0);
        dst_hit = wb_valid && (wb_reg == wr_dst) && (wr_dst != 5'd0);
        // a retire this cycle is already visible to the reader (write-first RF)
        rs_eff  = cnt_reg[id_rs] - CNT_W'(rs_hit && (cnt_reg[id_rs] != '0));
        rt_eff  = cnt_reg[id_rt] - CNT_W'(rt_hit && (cnt_reg[id_rt] != '0));
        // a full counter can still accept a writer if it retires one this cycle
        dst_full = wr_en && (cnt_reg[wr_dst] == CNT_MAX) && !dst_hit;
        stall = id_valid && ((id_read_rs && (rs_eff != '0)) ||
                             (id_read_rt && (rt_eff != '0)) ||
                             dst_full);
    end

    assign issue = id_valid && !stall;

    // ---------------- per-register counters ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign cnt_next[gi]     = '0;
                assign pending_mask[gi] = 1'b0;
            end else begin : g_track
                logic hit, inc, dec;
                assign hit = wb_valid && (wb_reg == 5'(gi));
                assign inc = issue && wr_en && (wr_dst == 5'(gi));
                assign dec = hit && (cnt_reg[gi] != '0);
                // inc at CNT_MAX only happens together with dec, so no wrap
                assign cnt_next[gi]     = cnt_reg[gi] + CNT_W'(inc) - CNT_W'(dec);
                assign pending_mask[gi] = (cnt_reg[gi] != '0);
            end
        end
    endgenerate

    assign underflow_hit = wb_valid && (wb_reg != 5'd0) && (cnt_reg[wb_reg] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_reg[i] <= '0;
            end
            wb_underflow_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            wb_underflow_reg <= wb_underflow_reg | underflow_hit;
        end
    end

    assign wb_underflow = wb_underflow_reg;

endmodule
